// File: rtl/demux_1to2_buf_if.sv
// -----------------------------------------------------------------------------
// demux_1to2_buf_if
// Stream bundle for the buffered 1-to-2 demultiplexer.
//   data_i/select_i/valid_i/ready_o : input stream, select_i picks the channel
//   data0_o/valid0_o/ready0_i       : channel 0 output stream
//   data1_o/valid1_o/ready1_i       : channel 1 output stream
//   cnt0_o/cnt1_o                   : per-channel accepted-word counters
// slave  : the demultiplexer side
// master : the producer/consumer environment side
// -----------------------------------------------------------------------------
interface demux_1to2_buf_if #(
  parameter int size  = 32,
  parameter int CNT_W = 16
);
  logic [size-1:0]  data_i;
  logic             select_i;
  logic             valid_i;
  logic             ready_o;
  logic [size-1:0]  data0_o;
  logic             valid0_o;
  logic             ready0_i;
  logic [size-1:0]  data1_o;
  logic             valid1_o;
  logic             ready1_i;
  logic [CNT_W-1:0] cnt0_o;
  logic [CNT_W-1:0] cnt1_o;

  modport slave (
    input  data_i, select_i, valid_i, ready0_i, ready1_i,
    output ready_o, data0_o, valid0_o, data1_o, valid1_o, cnt0_o, cnt1_o
  );

  modport master (
    output data_i, select_i, valid_i, ready0_i, ready1_i,
    input  ready_o, data0_o, valid0_o, data1_o, valid1_o, cnt0_o, cnt1_o
  );
endinterface

// File: rtl/demux_1to2_buf.sv
// -----------------------------------------------------------------------------
// demux_1to2_buf
// Steers one valid/ready input stream to one of two output streams. Each output
// channel owns a 2-entry in-order FIFO so a stalled consumer never blocks the
// other channel.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset, empties both FIFOs, clears counters
//   bus   : demux_1to2_buf_if.slave (input stream, two output streams, counters)
// -----------------------------------------------------------------------------
module demux_1to2_buf #(
  parameter int size  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  demux_1to2_buf_if.slave   bus
);

  // Per-channel state, index 0 = channel 0, index 1 = channel 1.
  logic [1:0]       occ    [2];   // 0, 1 or 2 words held
  logic [1:0]       rd_ptr;       // one head pointer bit per channel
  logic [1:0]       wr_ptr;       // one tail pointer bit per channel
  logic [CNT_W-1:0] cnt    [2];
  logic [size-1:0]  mem    [2][2];  // [channel][entry]

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] sel_oh;
  logic [1:0] rdy_in;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  // NOTE: every bit is assigned on every pass through the loop, so no latch
  // can be inferred even without a separate default line.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = (occ[c] == 2'd2);
      empty[c] = (occ[c] == 2'd0);
    end
  end

  // ready_o looks only at the selected FIFO; output-side readies never feed
  // back into it, which keeps the input path free of consumer timing.
  assign bus.ready_o = bus.select_i ? ~full[1] : ~full[0];
  assign accept      = bus.valid_i & bus.ready_o;
  assign sel_oh      = {bus.select_i, ~bus.select_i};
  assign push        = {2{accept}} & sel_oh;
  assign rdy_in      = {bus.ready1_i, bus.ready0_i};
  assign pop         = ~empty & rdy_in;

  // Control state: occupancy, pointers, counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int c = 0; c < 2; c++) begin
        occ[c] <= 2'd0;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= ~wr_ptr[c];
          cnt[c]    <= cnt[c] + CNT_W'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
        end
        // Push into a full FIFO is already blocked by ready_o, and pop from
        // an empty one by valid, so occupancy never leaves 0..2.
        case ({push[c], pop[c]})
          2'b10:   occ[c] <= occ[c] + 2'd1;
          2'b01:   occ[c] <= occ[c] - 2'd1;
          default: occ[c] <= occ[c];
        endcase
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; reset empties the FIFO
  // through occupancy, and the output mux forces zero whenever it is empty,
  // so stale contents are never observable.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= bus.data_i;
      end
    end
  end

  assign bus.valid0_o = ~empty[0];
  assign bus.valid1_o = ~empty[1];
  assign bus.data0_o  = empty[0] ? '0 : mem[0][rd_ptr[0]];
  assign bus.data1_o  = empty[1] ? '0 : mem[1][rd_ptr[1]];
  assign bus.cnt0_o   = cnt[0];
  assign bus.cnt1_o   = cnt[1];

endmodule

// File: tb/tb_demux_1to2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2_buf
// Self-checking bench for demux_1to2_buf. A word-queue reference model per
// channel is updated every cycle from the handshake rules; directed scenarios
// are followed by a randomized phase with random consumer back-pressure.
// -----------------------------------------------------------------------------
module tb_demux_1to2_buf;

  localparam int SIZE  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_i;

  demux_1to2_buf_if #(.size(SIZE), .CNT_W(CNT_W)) bus ();

  demux_1to2_buf #(.size(SIZE), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of expected words per channel plus a count of
  // accepted words per channel.
  logic [SIZE-1:0] q0[$];
  logic [SIZE-1:0] q1[$];
  int              n0 = 0;
  int              n1 = 0;
  bit              acc = 1'b0;  // the edge after this sample accepts the input
  bit              rand_en = 1'b0;

  // Monitor / scoreboard: samples at the falling edge, compares against the
  // model, then advances the model by what the coming rising edge will do.
  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst_i) begin
      q0.delete();
      q1.delete();
      n0  = 0;
      n1  = 0;
      acc = 1'b0;
      check("rst_valid0", bus.valid0_o, 0);
      check("rst_valid1", bus.valid1_o, 0);
      check("rst_data0",  bus.data0_o,  0);
      check("rst_data1",  bus.data1_o,  0);
      check("rst_cnt0",   bus.cnt0_o,   0);
      check("rst_cnt1",   bus.cnt1_o,   0);
    end else begin
      exp_rdy = bus.select_i ? (q1.size() < 2) : (q0.size() < 2);
      check("ready_o",  bus.ready_o,  exp_rdy);
      check("valid0_o", bus.valid0_o, q0.size() != 0);
      check("valid1_o", bus.valid1_o, q1.size() != 0);
      check("data0_o",  bus.data0_o,  (q0.size() != 0) ? q0[0] : '0);
      check("data1_o",  bus.data1_o,  (q1.size() != 0) ? q1[0] : '0);
      check("cnt0_o",   bus.cnt0_o,   n0 % (1 << CNT_W));
      check("cnt1_o",   bus.cnt1_o,   n1 % (1 << CNT_W));
      // Pops first, then the push: with one word held, the new word becomes
      // the head; with two held, exp_rdy was already 0 so nothing is pushed.
      if (bus.ready0_i && q0.size() != 0) void'(q0.pop_front());
      if (bus.ready1_i && q1.size() != 0) void'(q1.pop_front());
      acc = bus.valid_i && exp_rdy;
      if (acc) begin
        if (bus.select_i) begin q1.push_back(bus.data_i); n1++; end
        else              begin q0.push_back(bus.data_i); n0++; end
      end
    end
  end

  // Random consumer back-pressure during the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) begin
        bus.ready0_i = ($urandom_range(0, 3) != 0);
        bus.ready1_i = ($urandom_range(0, 1) != 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_word(input logic [SIZE-1:0] d, input logic s);
    bus.valid_i  = 1'b1;
    bus.data_i   = d;
    bus.select_i = s;
  endtask

  task automatic wait_accept();
    int k = 0;
    do begin
      tick();
      k++;
    end while (!acc && k < 60);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", bus.data_i, k);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drive(input logic [SIZE-1:0] d, input logic s);
    start_word(d, s);
    wait_accept();
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    rst_i        = 1'b0;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.select_i = 1'b0;
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    do_reset();

    // 1: single word to channel 0, consumed immediately.
    drive(32'hA5A5_A5A5, 1'b0);
    repeat (2) tick();

    // 2: three words to stalled channel 1; the third waits for space.
    bus.ready1_i = 1'b0;
    drive(32'h11, 1'b1);
    drive(32'h22, 1'b1);
    start_word(32'h33, 1'b1);
    repeat (3) tick();
    bus.ready1_i = 1'b1;
    wait_accept();
    repeat (3) tick();

    // 3: channel 0 full and stalled, channel 1 still flows.
    bus.ready0_i = 1'b0;
    drive(32'hC0, 1'b0);
    drive(32'hC1, 1'b0);
    drive(32'hD0, 1'b1);
    repeat (2) tick();
    bus.ready0_i = 1'b1;
    repeat (3) tick();

    // 4: push and pop together on channel 0 at occupancy 1.
    bus.ready0_i = 1'b0;
    drive(32'h40, 1'b0);
    bus.ready0_i = 1'b1;
    drive(32'h44, 1'b0);
    repeat (2) tick();

    // 5: counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) drive(32'h500 + i, 1'b0);
    repeat (2) tick();
    check("s5_cnt0_wrap", bus.cnt0_o, 1);
    check("s5_cnt1_zero", bus.cnt1_o, 0);

    // 6: asynchronous reset between edges with both FIFOs occupied.
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b0;
    drive(32'h61, 1'b0);
    drive(32'h62, 1'b0);
    drive(32'h63, 1'b1);
    @(posedge clk); #3;
    rst_i = 1'b0;
    #1;
    check("async_valid0", bus.valid0_o, 0);
    check("async_valid1", bus.valid1_o, 0);
    check("async_data0",  bus.data0_o,  0);
    check("async_data1",  bus.data1_o,  0);
    check("async_cnt0",   bus.cnt0_o,   0);
    check("async_cnt1",   bus.cnt1_o,   0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    tick();
    drive(32'hA5A5_A5A5, 1'b0);
    repeat (2) tick();

    // Randomized traffic with random back-pressure on both channels.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive($urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_en = 1'b0;
    tick();
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    repeat (4) tick();
    check("drain_valid0", bus.valid0_o, 0);
    check("drain_valid1", bus.valid1_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
